// File: rtl/ov7670_config_seq.sv
// rtl/ov7670_config_seq.sv - OV7670 register configuration sequencer driving an SCCB write master
//
// Walks a registered config ROM from address 0. Each word is {reg, data}.
// 16'hFFFF ends the sequence, and 16'hFFF0 inserts a pause of DELAY_MS ms.
// Every other word becomes one SCCB register write.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request to run the sequence (ignored while busy)
//   rom_addr    config ROM word address
//   rom_dout    ROM word, valid one clk after rom_addr changes
//   sccb_start  one-cycle write request to the SCCB master
//   sccb_reg    register address for the SCCB write
//   sccb_data   register data for the SCCB write
//   sccb_ready  SCCB master idle
//   busy        sequence running
//   done        end of sequence reached; held until next accepted start or rst
module ov7670_config_seq #(
    parameter int CLK_FREQ = 24000000,
    parameter int DELAY_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done
);

    localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
    localparam int CNT_W        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int LOAD_VAL     = (DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);

    localparam logic [15:0] WORD_END   = 16'hFFFF;
    localparam logic [15:0] WORD_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        ISSUED,
        WAIT_SCCB,
        DELAY,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] delay_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= 8'd0;
            sccb_start <= 1'b0;
            sccb_reg   <= 8'd0;
            sccb_data  <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            delay_cnt  <= '0;
        end else begin
            sccb_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= 8'd0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                // The ROM is registered, so rom_dout only reflects rom_addr
                // after this cycle.
                FETCH: state <= DECODE;

                DECODE: begin
                    if (rom_dout == WORD_END) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (rom_dout == WORD_DELAY) begin
                        delay_cnt <= CNT_LOAD;
                        state     <= DELAY;
                    end else begin
                        sccb_reg  <= rom_dout[15:8];
                        sccb_data <= rom_dout[7:0];
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (sccb_ready) begin
                        sccb_start <= 1'b1;
                        state      <= ISSUED;
                    end
                end

                // The master needs a cycle to drop sccb_ready after it sees
                // sccb_start, so ready is not trusted here.
                ISSUED: state <= WAIT_SCCB;

                WAIT_SCCB: begin
                    if (sccb_ready) begin
                        if (rom_addr == 8'hFF) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end
                end

                // Counts LOAD_VAL down to 0 inclusive, so the block stays here
                // for DELAY_CYCLES cycles in total.
                DELAY: begin
                    if (delay_cnt == '0) begin
                        if (rom_addr == 8'hFF) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb/tb_ov7670_config_seq.sv - self-checking bench for ov7670_config_seq
module tb_ov7670_config_seq;

    localparam int TB_CLK_FREQ = 1000;
    localparam int TB_DELAY_MS = 5;
    localparam int DC          = TB_CLK_FREQ / 1000 * TB_DELAY_MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] rom [256];
    int          lat = 5;
    int          busy_cnt = 0;
    logic        force_busy = 1'b0;

    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  exp_final;
    logic [15:0] last_rd = 16'h0;
    logic        prev_start = 1'b0;
    int          illegal = 0;
    int          unstable = 0;

    always #5 clk = ~clk;

    ov7670_config_seq #(
        .CLK_FREQ(TB_CLK_FREQ),
        .DELAY_MS(TB_DELAY_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rom_addr(rom_addr),
        .rom_dout(rom_dout),
        .sccb_start(sccb_start),
        .sccb_reg(sccb_reg),
        .sccb_data(sccb_data),
        .sccb_ready(sccb_ready),
        .busy(busy),
        .done(done)
    );

    // Registered ROM
    always @(posedge clk) rom_dout <= rom[rom_addr];

    // SCCB master: ready drops for lat cycles after each accepted start
    assign sccb_ready = !force_busy && (busy_cnt == 0);
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (sccb_start) busy_cnt <= lat;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Write monitor and protocol watch
    always @(posedge clk) begin
        if (sccb_start) begin
            obs_q.push_back({sccb_reg, sccb_data});
            last_rd = {sccb_reg, sccb_data};
            if (!sccb_ready) illegal++;
            if (prev_start) illegal++;
        end else if (busy_cnt != 0 && !rst && {sccb_reg, sccb_data} !== last_rd) begin
            unstable++;
        end
        prev_start = sccb_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: walk the ROM by the sequencing rules
    task automatic model();
        exp_q.delete();
        exp_final = 8'hFF;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_final = a[7:0];
                break;
            end
            if (rom[a] != 16'hFFF0) exp_q.push_back(rom[a]);
        end
    endtask

    task automatic rom_clear();
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
    endtask

    function automatic logic [15:0] rand_write();
        logic [15:0] w;
        w = 16'($urandom);
        while (w == 16'hFFFF || w == 16'hFFF0) w = 16'($urandom);
        return w;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int c = 0;
        while (!done && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic compare_run(input string tag);
        chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < obs_q.size()) chk({tag, "_write"}, {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
        chk({tag, "_addr"}, {24'd0, rom_addr}, {24'd0, exp_final});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_seq(input string tag, input bit inject, input int limit);
        model();
        obs_q.delete();
        pulse_start();
        chk({tag, "_start_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
        if (inject) begin
            repeat ($urandom_range(2, 12)) @(negedge clk);
            if (busy) pulse_start();
        end
        wait_done(limit);
        compare_run(tag);
    endtask

    initial begin
        int cnt;
        rom_clear();

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", {rom_addr, sccb_start, sccb_reg, sccb_data, busy, done},
            {8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Basic run
        rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF;
        lat = 5;
        run_seq("basic", 1'b0, 500);

        // Start in DONE repeats the sequence in full
        run_seq("restart", 1'b0, 500);

        // Delay marker timing
        rom_clear();
        rom[0] = 16'hFFF0; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
        model();
        obs_q.delete();
        pulse_start();
        chk("dly_addr0", {24'd0, rom_addr}, 32'd0);
        cnt = 0;
        while (rom_addr != 8'd1 && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("dly_cycles", cnt, 2 + DC);
        wait_done(500);
        compare_run("delay");

        // Backpressure in ISSUE
        rom_clear();
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        model();
        obs_q.delete();
        force_busy = 1'b1;
        pulse_start();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {15'd0, sccb_start, sccb_reg, sccb_data}, {15'd0, 1'b0, 16'h1280});
            @(negedge clk);
        end
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_pulse", {31'd0, sccb_start}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_pulse_end", {31'd0, sccb_start}, 32'd0);
        wait_done(500);
        compare_run("bp");

        // Reset mid-run in WAIT_SCCB of the second write
        rom_clear();
        rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h3a55; rom[3] = 16'hFFFF;
        lat = 5;
        obs_q.delete();
        pulse_start();
        cnt = 0;
        while (obs_q.size() < 2 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_two_writes", obs_q.size(), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_outs", {rom_addr, sccb_start, sccb_reg, sccb_data, busy, done},
            {8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_no_more", obs_q.size(), 2);
        run_seq("replay", 1'b0, 500);

        // rst overrides start in the same cycle
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_vs_start", {busy, done}, 2'b00);

        // Randomized sequences with delay markers and starts while busy
        for (int it = 0; it < 8; it++) begin
            int n;
            rom_clear();
            n = $urandom_range(1, 10);
            for (int a = 0; a < n; a++)
                rom[a] = ($urandom_range(0, 5) == 0) ? 16'hFFF0 : rand_write();
            lat = $urandom_range(1, 6);
            run_seq("rand", 1'b1, 2000);
        end

        // No end marker: 256 writes then DONE at 255
        for (int a = 0; a < 256; a++) rom[a] = rand_write();
        lat = 1;
        run_seq("full", 1'b0, 10000);

        chk("illegal_start", illegal, 0);
        chk("reg_stable", unstable, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
